// File: rtl/ecc_scrub_pkg.sv
// ecc_scrub_pkg: shared FSM state encoding, error classes and word-format constants for the ECC scrubber
package ecc_scrub_pkg;
  localparam int CW_W   = 72;
  localparam int WORD_W = 80;
  localparam int SYN_W  = 8;
  typedef enum logic [2:0] {
    S_IDLE, S_RD_REQ, S_RD_WAIT, S_CHECK, S_WR_REQ, S_NEXT, S_DONE
  } state_t;
  typedef enum logic [1:0] {CLEAN, CE, UE} err_t;
endpackage

// File: rtl/ecc_scrub_ctrl_syn_class.sv
// ecc_syn_class: classifies a SEC-DED syndrome as clean, correctable (odd weight) or uncorrectable
module ecc_syn_class
  import ecc_scrub_pkg::*;
(
  input  logic [SYN_W-1:0] i_syn,
  output err_t             o_class
);
  always_comb o_class = (i_syn == '0) ? CLEAN : (^i_syn ? CE : UE);
endmodule

// File: rtl/ecc_scrub_ctrl.sv
// ecc_scrub_ctrl: walks a memory range, reads each word, counts CE/UE and writes back corrected words.
// Defining ECC_SCRUB_WB_EN enables the write-back path; otherwise correctable words are only counted.
module ecc_scrub_ctrl
  import ecc_scrub_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   word_cnt,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WORD_W-1:0] mem_wdata,
  input  logic              mem_gnt,
  input  logic              mem_rvalid,
  input  logic [WORD_W-1:0] mem_rdata,
  output logic [WORD_W-1:0] dec_word,
  input  logic [SYN_W-1:0]  syn,
  input  logic [CW_W-1:0]   dec_cw,
  output logic              busy,
  output logic              done,
  output logic              ue_irq,
  output logic [CNT_W-1:0]  ce_cnt,
  output logic [CNT_W-1:0]  ue_cnt,
  output logic [ADDR_W-1:0] ue_addr
);
  state_t              r_state, w_next;
  err_t                w_class;
  logic [ADDR_W-1:0]   r_addr, r_ue_addr;
  logic [ADDR_W:0]     r_cnt;
  logic                r_mem_req, r_ue_irq, w_accept;
  logic [WORD_W-1:0]   r_dec_word;
  logic [CNT_W-1:0]    r_ce_cnt, r_ue_cnt;

  ecc_syn_class u_class (.i_syn(syn), .o_class(w_class));

  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:    if (start) w_next = (word_cnt == '0) ? S_DONE : S_RD_REQ;
      S_RD_REQ:  if (mem_gnt) w_next = S_RD_WAIT;
      S_RD_WAIT: if (mem_rvalid) w_next = S_CHECK;
`ifdef ECC_SCRUB_WB_EN
      S_CHECK:   w_next = (w_class == CE) ? S_WR_REQ : S_NEXT;
      S_WR_REQ:  if (mem_gnt) w_next = S_NEXT;
`else
      S_CHECK:   w_next = S_NEXT;
`endif
      S_NEXT:    w_next = (r_cnt == 1) ? S_DONE : S_RD_REQ;
      S_DONE:    w_next = S_IDLE;
      default:   w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_addr     <= '0;
      r_cnt      <= '0;
      r_mem_req  <= 1'b0;
      r_dec_word <= '0;
      r_ce_cnt   <= '0;
      r_ue_cnt   <= '0;
      r_ue_irq   <= 1'b0;
      r_ue_addr  <= '0;
    end else begin
      r_state   <= w_next;
      r_mem_req <= (w_next == S_RD_REQ) || (w_next == S_WR_REQ);
      if (w_accept) begin
        r_addr   <= base_addr;
        r_cnt    <= word_cnt;
        r_ce_cnt <= '0;
        r_ue_cnt <= '0;
        r_ue_irq <= 1'b0;
      end
      if (r_state == S_RD_WAIT && mem_rvalid) r_dec_word <= mem_rdata;
      if (r_state == S_CHECK && w_class == CE && r_ce_cnt != '1) r_ce_cnt <= r_ce_cnt + 1'b1;
      if (r_state == S_CHECK && w_class == UE) begin
        if (r_ue_cnt != '1) r_ue_cnt <= r_ue_cnt + 1'b1;
        if (!r_ue_irq) begin
          r_ue_irq  <= 1'b1;
          r_ue_addr <= r_addr;
        end
      end
      if (r_state == S_NEXT) begin
        r_cnt  <= r_cnt - 1'b1;
        r_addr <= r_addr + 1'b1;
      end
    end
  end

`ifdef ECC_SCRUB_WB_EN
  logic              r_mem_we;
  logic [WORD_W-1:0] r_wdata;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mem_we <= 1'b0;
      r_wdata  <= '0;
    end else begin
      r_mem_we <= (w_next == S_WR_REQ);
      if (r_state == S_CHECK && w_class == CE) r_wdata <= {r_dec_word[WORD_W-1:CW_W], dec_cw};
    end
  end
  assign mem_we    = r_mem_we;
  assign mem_wdata = r_wdata;
`else
  logic w_unused_cw;
  assign w_unused_cw = ^dec_cw;
  assign mem_we      = 1'b0;
  assign mem_wdata   = '0;
`endif

  assign mem_req  = r_mem_req;
  assign mem_addr = r_addr;
  assign dec_word = r_dec_word;
  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign ue_irq   = r_ue_irq;
  assign ce_cnt   = r_ce_cnt;
  assign ue_cnt   = r_ue_cnt;
  assign ue_addr  = r_ue_addr;
endmodule
